sync_gray_ptr_level: RTL and testbench

Parametrised successor to the FIFO pointer synchroniser, living in the read-clock domain of the async FIFO.
- Brings a Gray-coded write pointer across through a configurable-depth flop chain.
- Converts the synchronised pointer to binary and computes fill level, empty and almost-empty against the local binary read pointer.
- Flags illegal Gray transitions and level overflow with sticky error bits for debug of the scope capture path.

---
 rtl/sync_gray_ptr_level.sv | 126 ++++++++++++
 tb/tb_sync_gray_ptr_level.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_gray_ptr_level.sv
// Read-domain side of the async FIFO: synchronises the Gray write pointer,
// converts it to binary and derives fill level, empty flags and sticky debug errors.
module sync_gray_ptr_level #(
  parameter int ADDR_SIZE   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input  logic               r_clk_i,
  input  logic               r_rst_i,
  input  logic [ADDR_SIZE:0] w_ptr_gray_i,
  input  logic [ADDR_SIZE:0] r_ptr_bin_i,
  input  logic               err_clr_i,
  output logic [ADDR_SIZE:0] r_w_ptr_gray_o,
  output logic [ADDR_SIZE:0] r_w_ptr_bin_o,
  output logic [ADDR_SIZE:0] level_o,
  output logic               empty_o,
  output logic               almost_empty_o,
  output logic               ptr_valid_o,
  output logic               gray_err_o,
  output logic               level_err_o
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] DEPTH      = PW'(2 ** ADDR_SIZE);
  localparam logic [PW-1:0] AE_LIMIT   = PW'(AE_THRESH);
  localparam logic [2:0]    FLUSH_LAST = 3'(SYNC_STAGES + 1);

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_stages
    $error("sync_gray_ptr_level: SYNC_STAGES must be 2..4");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > (2 ** ADDR_SIZE))) begin : g_bad_thresh
    $error("sync_gray_ptr_level: AE_THRESH must be 0..2**ADDR_SIZE");
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit differs between a and b.
  function automatic logic multi_bit_change(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] x;
    logic          seen;
    logic          multi;
    x     = a ^ b;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < PW; i++) begin
      multi = multi | (seen & x[i]);
      seen  = seen | x[i];
    end
    return multi;
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] prev_q, prev_d;
  logic [PW-1:0] bin_q, bin_d;
  logic [2:0]    flush_q, flush_d;
  logic          valid_q, valid_d;
  logic          gray_err_q, gray_err_d;
  logic          level_err_q, level_err_d;
  logic [PW-1:0] level_s;

  // Modulo subtraction: the extra wrap bit makes pointer wrap-around transparent.
  always_comb begin
    level_s = bin_q - r_ptr_bin_i;
  end

  always_comb begin
    sync_d[0] = w_ptr_gray_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    bin_d  = gray2bin(sync_q[SYNC_STAGES-1]);
    if (flush_q == FLUSH_LAST) begin
      flush_d = flush_q;
    end else begin
      flush_d = flush_q + 3'd1;
    end
    valid_d     = (flush_d == FLUSH_LAST);
    // Set has priority over clear when both happen on the same edge.
    gray_err_d  = (valid_q & multi_bit_change(sync_q[SYNC_STAGES-1], prev_q))
                | (gray_err_q & ~err_clr_i);
    level_err_d = (valid_q & (level_s > DEPTH)) | (level_err_q & ~err_clr_i);
  end

  always_ff @(posedge r_clk_i) begin
    if (!r_rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {PW{1'b0}};
      end
      prev_q      <= {PW{1'b0}};
      bin_q       <= {PW{1'b0}};
      flush_q     <= 3'd0;
      valid_q     <= 1'b0;
      gray_err_q  <= 1'b0;
      level_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      prev_q      <= prev_d;
      bin_q       <= bin_d;
      flush_q     <= flush_d;
      valid_q     <= valid_d;
      gray_err_q  <= gray_err_d;
      level_err_q <= level_err_d;
    end
  end

  assign r_w_ptr_gray_o = sync_q[SYNC_STAGES-1];
  assign r_w_ptr_bin_o  = bin_q;
  assign level_o        = level_s;
  assign ptr_valid_o    = valid_q;
  assign empty_o        = (level_s == {PW{1'b0}}) | ~valid_q;
  assign almost_empty_o = (level_s <= AE_LIMIT) | ~valid_q;
  assign gray_err_o     = gray_err_q;
  assign level_err_o    = level_err_q;

endmodule

// File: tb/tb_sync_gray_ptr_level.sv
// Bench for sync_gray_ptr_level: SYNC_STAGES=2 and =3 instances share stimulus and
// are compared against a sample-history model of the pointer crossing.
module tb_sync_gray_ptr_level;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [8:0] w_gray;
  logic [8:0] rp;

  logic [8:0] gray2, bin2, lvl2;
  logic       emp2, ae2, val2, ge2, le2;
  logic [8:0] gray3, bin3, lvl3;
  logic       emp3, ae3, val3, ge3, le3;

  int checks = 0;
  int errors = 0;

  logic [8:0] samp[$];   // samp[0] = most recent sampled write pointer
  int         edges;     // edges since reset release
  logic       gerr_m[2];
  logic       lerr_m[2];

  always #5 clk = ~clk;

  sync_gray_ptr_level #(.ADDR_SIZE(8), .SYNC_STAGES(2), .AE_THRESH(4)) dut2 (
    .r_clk_i(clk), .r_rst_i(rst_n), .w_ptr_gray_i(w_gray), .r_ptr_bin_i(rp),
    .err_clr_i(clr), .r_w_ptr_gray_o(gray2), .r_w_ptr_bin_o(bin2), .level_o(lvl2),
    .empty_o(emp2), .almost_empty_o(ae2), .ptr_valid_o(val2),
    .gray_err_o(ge2), .level_err_o(le2));

  sync_gray_ptr_level #(.ADDR_SIZE(8), .SYNC_STAGES(3), .AE_THRESH(4)) dut3 (
    .r_clk_i(clk), .r_rst_i(rst_n), .w_ptr_gray_i(w_gray), .r_ptr_bin_i(rp),
    .err_clr_i(clr), .r_w_ptr_gray_o(gray3), .r_w_ptr_bin_o(bin3), .level_o(lvl3),
    .empty_o(emp3), .almost_empty_o(ae3), .ptr_valid_o(val3),
    .gray_err_o(ge3), .level_err_o(le3));

  function automatic logic [8:0] m_gray(input int s);
    if (samp.size() >= s) return samp[s-1];
    return 9'd0;
  endfunction

  // Previous synchronised output, i.e. the sample one edge older.
  function automatic logic [8:0] m_prev(input int s);
    if (samp.size() >= s + 1) return samp[s];
    return 9'd0;
  endfunction

  function automatic logic [8:0] m_bin(input int s);
    logic [8:0] g;
    logic [8:0] b;
    g = m_prev(s);
    b = g;
    for (int sh = 1; sh < 9; sh++) b = b ^ (g >> sh);
    return b;
  endfunction

  function automatic logic m_valid(input int s);
    return edges >= s + 1;
  endfunction

  function automatic logic [8:0] m_level(input int s);
    logic [8:0] l;
    l = m_bin(s) - rp;
    return l;
  endfunction

  task automatic m_edge();
    logic set_g;
    logic set_l;
    if (!rst_n) begin
      samp.delete();
      edges = 0;
      for (int i = 0; i < 2; i++) begin
        gerr_m[i] = 1'b0;
        lerr_m[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        set_g = m_valid(i + 2) && ($countones(m_gray(i + 2) ^ m_prev(i + 2)) > 1);
        set_l = m_valid(i + 2) && (m_level(i + 2) > 9'd256);
        gerr_m[i] = set_g | (gerr_m[i] & ~clr);
        lerr_m[i] = set_l | (lerr_m[i] & ~clr);
      end
      samp.push_front(w_gray);
      if (samp.size() > 6) void'(samp.pop_back());
      if (edges < 50) edges++;
    end
  endtask

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input string p, input int s, input logic [8:0] g,
                            input logic [8:0] b, input logic [8:0] l, input logic e,
                            input logic ae, input logic v, input logic ge, input logic le);
    logic [8:0] lv;
    lv = m_level(s);
    chk({p, "gray"}, g, m_gray(s));
    chk({p, "bin"}, b, m_bin(s));
    chk({p, "level"}, l, lv);
    chk({p, "empty"}, {8'd0, e}, {8'd0, (lv == 9'd0) || !m_valid(s)});
    chk({p, "almost_empty"}, {8'd0, ae}, {8'd0, (lv <= 9'd4) || !m_valid(s)});
    chk({p, "ptr_valid"}, {8'd0, v}, {8'd0, m_valid(s)});
    chk({p, "gray_err"}, {8'd0, ge}, {8'd0, gerr_m[s-2]});
    chk({p, "level_err"}, {8'd0, le}, {8'd0, lerr_m[s-2]});
  endtask

  task automatic check_all();
    check_inst("s2_", 2, gray2, bin2, lvl2, emp2, ae2, val2, ge2, le2);
    check_inst("s3_", 3, gray3, bin3, lvl3, emp3, ae3, val3, ge3, le3);
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic look();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] wb;
    logic [8:0] rb;
    int         r;
    rst_n = 1'b0;
    clr   = 1'b0;
    w_gray = 9'd0;
    rp    = 9'd0;
    edges = 0;
    #2;

    // reset and flush with inputs held at zero
    do_reset();
    repeat (5) tick();

    // legal Gray walk bin 0..5, then level 4 crosses the almost-empty threshold
    foreach (samp[i]) begin end
    w_gray = 9'h001; tick();
    w_gray = 9'h003; tick();
    w_gray = 9'h002; tick();
    w_gray = 9'h006; tick();
    w_gray = 9'h007; tick();
    repeat (4) tick();
    rp = 9'd1;
    look();

    // wrap-around level and same-cycle empty on read-pointer step
    do_reset();
    w_gray = 9'h182;
    rp = 9'h0FE;
    repeat (6) tick();
    rp = 9'h103;
    look();

    // illegal jump, sticky, clear, then set and clear on the same edge
    rp = 9'd0;
    w_gray = 9'h000;
    do_reset();
    repeat (5) tick();
    w_gray = 9'h003;
    repeat (5) tick();
    clr = 1'b1; tick();
    clr = 1'b0; tick();
    w_gray = 9'h000;
    clr = 1'b1;
    repeat (4) tick();
    clr = 1'b0;
    tick();

    // level overflow
    do_reset();
    w_gray = 9'h181;
    repeat (6) tick();

    // mid-stream reset at level 5 and clean re-flush
    w_gray = 9'h000;
    do_reset();
    w_gray = 9'h007;
    repeat (6) tick();
    do_reset();
    repeat (6) tick();

    // randomized pointer traffic with occasional illegal jumps, clears and resets
    wb = 9'd5;
    rb = 9'd0;
    rp = rb;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 199));
      if (r < 100) wb = wb + 9'd1;
      if (r == 7) wb = wb + 9'($urandom_range(2, 300));
      if ((rb != wb) && ($urandom_range(0, 1) == 1)) rb = rb + 9'd1;
      w_gray = wb ^ (wb >> 1);
      rp = rb;
      clr = ($urandom_range(0, 15) == 0);
      rst_n = (r != 199);
      tick();
    end
    rst_n = 1'b1;
    clr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
